// File: rtl/set_assoc_cache.sv
// Write-back, write-allocate set-associative cache with a single line-wide memory port.
// Replacement is true LRU by default; define CACHE_FIFO_REPLACE_EN for a per-set FIFO pointer.
module set_assoc_cache #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int SET_ADDR_LEN  = 2,
    parameter int WAY_CNT       = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [31:0]                        addr,
    input  logic                               rd_req,
    input  logic                               wr_req,
    input  logic [3:0]                         wr_be,
    input  logic [31:0]                        wr_data,
    output logic [31:0]                        rd_data,
    output logic                               miss,
    output logic                               mem_rd_req,
    output logic                               mem_wr_req,
    output logic [31:0]                        mem_addr,
    output logic [32*(2**LINE_ADDR_LEN)-1:0]   mem_wr_line,
    input  logic [32*(2**LINE_ADDR_LEN)-1:0]   mem_rd_line,
    input  logic                               mem_gnt
);
    localparam int TAG_ADDR_LEN = 30 - LINE_ADDR_LEN - SET_ADDR_LEN;
    localparam int WORDS        = 1 << LINE_ADDR_LEN;
    localparam int SETS         = 1 << SET_ADDR_LEN;
    localparam int WAY_BITS     = (WAY_CNT > 1) ? $clog2(WAY_CNT) : 1;

    typedef enum logic [1:0] {IDLE, SWAP_OUT, SWAP_IN, SWAP_IN_OK} state_t;
    state_t state, state_next;

    logic [32*WORDS-1:0]                  line_mem [SETS][WAY_CNT];
    logic [TAG_ADDR_LEN-1:0]              tag_mem  [SETS][WAY_CNT];
    logic [SETS-1:0][WAY_CNT-1:0]         valid;
    logic [SETS-1:0][WAY_CNT-1:0]         dirty;

    logic [TAG_ADDR_LEN-1:0]  cur_tag, lat_tag;
    logic [SET_ADDR_LEN-1:0]  cur_set, lat_set;
    logic [LINE_ADDR_LEN-1:0] cur_word;
    logic [WAY_BITS-1:0]      hit_way, victim, lat_victim, policy_way;
    logic [32*WORDS-1:0]      fill_line, merged_line;
    logic                     req, hit, found_invalid, unused_bits;

    assign cur_tag     = addr[31 -: TAG_ADDR_LEN];
    assign cur_set     = addr[2+LINE_ADDR_LEN +: SET_ADDR_LEN];
    assign cur_word    = addr[2 +: LINE_ADDR_LEN];
    assign unused_bits = &{1'b0, addr[1:0]};
    assign req         = rd_req | wr_req;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAY_CNT; w++) begin
            if (!hit && valid[cur_set][w] && tag_mem[cur_set][w] == cur_tag) begin
                hit     = 1'b1;
                hit_way = WAY_BITS'(w);
            end
        end
        if (state != IDLE || !req) hit = 1'b0;
    end

    assign rd_data = hit ? line_mem[cur_set][hit_way][32*cur_word +: 32] : 32'h0;

    // Empty ways are always filled first, lowest index winning; the policy only breaks full sets.
    always_comb begin
        found_invalid = 1'b0;
        victim        = policy_way;
        for (int w = 0; w < WAY_CNT; w++) begin
            if (!found_invalid && !valid[cur_set][w]) begin
                found_invalid = 1'b1;
                victim        = WAY_BITS'(w);
            end
        end
    end

`ifdef CACHE_FIFO_REPLACE_EN
    logic [SETS-1:0][WAY_BITS-1:0] fifo_ptr;

    assign policy_way = fifo_ptr[cur_set];

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_ptr <= '0;
        end else if (state == SWAP_IN_OK) begin
            fifo_ptr[lat_set] <= (fifo_ptr[lat_set] == WAY_BITS'(WAY_CNT - 1)) ? '0
                                 : fifo_ptr[lat_set] + 1'b1;
        end
    end
`else
    logic [SETS-1:0][WAY_CNT-1:0][WAY_BITS-1:0] age;
    logic [WAY_CNT-1:0][WAY_BITS-1:0]           age_set, age_next;
    logic [SET_ADDR_LEN-1:0]                    upd_set;
    logic [WAY_BITS-1:0]                        upd_way;
    logic                                       upd_en, upd_fresh;

    assign upd_en    = hit || (state == SWAP_IN_OK);
    assign upd_set   = (state == SWAP_IN_OK) ? lat_set : cur_set;
    assign upd_way   = (state == SWAP_IN_OK) ? lat_victim : hit_way;
    assign upd_fresh = (state == SWAP_IN_OK) && !valid[lat_set][lat_victim];

    always_comb begin
        policy_way = '0;
        for (int w = 1; w < WAY_CNT; w++) begin
            if (age[cur_set][w] > age[cur_set][policy_way]) policy_way = WAY_BITS'(w);
        end
    end

    // Filling an empty way ages every resident line, keeping valid ages a dense 0..k-1 ranking.
    always_comb begin
        age_set  = age[upd_set];
        age_next = age_set;
        for (int w = 0; w < WAY_CNT; w++) begin
            if (WAY_BITS'(w) == upd_way) begin
                age_next[w] = '0;
            end else if ((age_set[w] < age_set[upd_way]) || (upd_fresh && valid[upd_set][w])) begin
                age_next[w] = age_set[w] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            age <= '0;
        end else if (upd_en) begin
            age[upd_set] <= age_next;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next  = state;
        miss        = 1'b1;
        mem_rd_req  = 1'b0;
        mem_wr_req  = 1'b0;
        mem_addr    = '0;
        mem_wr_line = '0;
        case (state)
            IDLE: begin
                miss = req && !hit;
                if (req && !hit) begin
                    state_next = (valid[cur_set][victim] && dirty[cur_set][victim]) ? SWAP_OUT : SWAP_IN;
                end
            end
            SWAP_OUT: begin
                mem_wr_req  = 1'b1;
                mem_addr    = {tag_mem[lat_set][lat_victim], lat_set, {(LINE_ADDR_LEN+2){1'b0}}};
                mem_wr_line = line_mem[lat_set][lat_victim];
                if (mem_gnt) state_next = SWAP_IN;
            end
            SWAP_IN: begin
                mem_rd_req = 1'b1;
                mem_addr   = {lat_tag, lat_set, {(LINE_ADDR_LEN+2){1'b0}}};
                if (mem_gnt) state_next = SWAP_IN_OK;
            end
            SWAP_IN_OK: state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && req && !hit) begin
            lat_tag    <= cur_tag;
            lat_set    <= cur_set;
            lat_victim <= victim;
        end
        if (state == SWAP_IN && mem_gnt) fill_line <= mem_rd_line;
    end

    always_comb begin
        merged_line = line_mem[cur_set][hit_way];
        for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) merged_line[32*cur_word + 8*b +: 8] = wr_data[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            dirty <= '0;
        end else if (state == SWAP_IN_OK) begin
            valid[lat_set][lat_victim] <= 1'b1;
            dirty[lat_set][lat_victim] <= 1'b0;
        end else if (hit && wr_req) begin
            dirty[cur_set][hit_way] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == SWAP_IN_OK) begin
                tag_mem[lat_set][lat_victim]  <= lat_tag;
                line_mem[lat_set][lat_victim] <= fill_line;
            end else if (hit && wr_req) begin
                line_mem[cur_set][hit_way] <= merged_line;
            end
        end
    end
endmodule
